regfile_wr_arbiter: RTL and testbench

//   Shares the single register-file write port between two writeback requesters:

---
 rtl/regfile_wr_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_wr_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single register-file write port between two writeback
//   requesters: port 0 (ALU/execute result, fixed priority) and port 1
//   (memory/load result). A starvation counter forces a port-1 grant after
//   STARVE_LIMIT consecutive port-1 losses. The winning write is registered
//   and presented to the register file one cycle after acceptance. The same
//   flops also feed the forwarding unit.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req0_valid/addr/data, ready   port 0 write request (valid/ready handshake)
//   req1_valid/addr/data, ready   port 1 write request (valid/ready handshake)
//   rf_wr_en/addr/data            registered register-file write port
//   fw_valid/addr/data            forwarding copy of rf_wr_*
//   starve_cnt                    current port-1 loss count (debug)
//
// STARVE_LIMIT must lie in 1..15 so the 4-bit counter cannot wrap.
module regfile_wr_arbiter #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wr_en,
    output logic [ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0] rf_wr_data,
    output logic                  fw_valid,
    output logic [ADDR_WIDTH-1:0] fw_addr,
    output logic [DATA_WIDTH-1:0] fw_data,
    output logic [3:0]            starve_cnt
);

    typedef enum logic {PRIO0, PRIO1} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt_nxt;

    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        state_nxt  = state;
        cnt_nxt    = starve_cnt;
        case (state)
            PRIO0: begin
                req0_ready = req0_valid;
                req1_ready = req1_valid & ~req0_valid;
                if (req1_ready) begin
                    cnt_nxt = 4'd0;
                end else if (req1_valid) begin
                    cnt_nxt = starve_cnt + 4'd1;
                    // The loss that reaches the limit hands the next cycle to port 1.
                    if (cnt_nxt == 4'(STARVE_LIMIT))
                        state_nxt = PRIO1;
                end
            end
            PRIO1: begin
                req1_ready = req1_valid;
                req0_ready = req0_valid & ~req1_valid;
                // Port 1 either wins now or has withdrawn; either way the
                // forced turn is over.
                state_nxt  = PRIO0;
                cnt_nxt    = 4'd0;
            end
            default: begin
                state_nxt = PRIO0;
                cnt_nxt   = 4'd0;
            end
        endcase
        // No handshakes while reset is held.
        if (!rst_n) begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= PRIO0;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= cnt_nxt;
        end
    end

    // Address/data hold their last value when nothing is accepted, so only
    // the enable toggles on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else if (req0_ready) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= req0_addr;
            rf_wr_data <= req0_data;
        end else if (req1_ready) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= req1_addr;
            rf_wr_data <= req1_data;
        end else begin
            rf_wr_en   <= 1'b0;
        end
    end

    assign fw_valid = rf_wr_en;
    assign fw_addr  = rf_wr_addr;
    assign fw_data  = rf_wr_data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int LIMIT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic [DW-1:0] req0_data = '0, req1_data = '0;
    logic          req0_ready, req1_ready;
    logic          rf_wr_en, fw_valid;
    logic [AW-1:0] rf_wr_addr, fw_addr;
    logic [DW-1:0] rf_wr_data, fw_data;
    logic [3:0]    starve_cnt;

    regfile_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
        .fw_valid(fw_valid), .fw_addr(fw_addr), .fw_data(fw_data),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] m_rf [16];  // register file as the model expects it
    logic [DW-1:0] d_rf [16];  // register file as built from DUT writes

    // Reference model state: number of consecutive port-1 losses, and whether
    // the next cycle is port 1's forced turn.
    int   m_losses = 0;
    bit   m_forced = 1'b0;
    int   exp_cnt  = 0;
    bit   g0, g1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already driven. Evaluates the grant
    // rules, checks the readies, queues the expected write, and returns at
    // the next negedge.
    task automatic cycle();
        #2;
        if (m_forced) begin
            g1 = req1_valid;
            g0 = req0_valid && !req1_valid;
        end else begin
            g0 = req0_valid;
            g1 = req1_valid && !req0_valid;
        end
        chk("req0_ready", 64'(req0_ready), 64'(g0));
        chk("req1_ready", 64'(req1_ready), 64'(g1));
        if (g0) begin
            exp_q.push_back('{addr: req0_addr, data: req0_data});
            m_rf[req0_addr] = req0_data;
        end else if (g1) begin
            exp_q.push_back('{addr: req1_addr, data: req1_data});
            m_rf[req1_addr] = req1_data;
        end
        if (m_forced || g1) begin
            m_losses = 0;
            m_forced = 1'b0;
        end else if (req1_valid) begin
            m_losses++;
            if (m_losses >= LIMIT) m_forced = 1'b1;
        end
        exp_cnt = m_losses;
        @(negedge clk);
    endtask

    // Monitor: every committed write must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("starve_cnt", 64'(starve_cnt), 64'(exp_cnt));
            chk("fw_valid", 64'(fw_valid), 64'(rf_wr_en));
            if (rf_wr_en) begin
                chk("fw_addr", 64'(fw_addr), 64'(rf_wr_addr));
                chk("fw_data", 64'(fw_data), 64'(rf_wr_data));
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(rf_wr_en), 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("rf_wr_addr", 64'(rf_wr_addr), 64'(e.addr));
                    chk("rf_wr_data", 64'(rf_wr_data), 64'(e.data));
                end
                d_rf[rf_wr_addr] = rf_wr_data;
            end
            if (exp_q.size() != 0) begin
                chk("missed_write", 64'(exp_q.size()), 64'd0);
                exp_q.delete();
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_en"}, 64'(rf_wr_en), 64'd0);
        chk({tag, "_addr"}, 64'(rf_wr_addr), 64'd0);
        chk({tag, "_data"}, 64'(rf_wr_data), 64'd0);
        chk({tag, "_fw"}, {31'd0, fw_valid, 28'(fw_addr), fw_data[3:0]}, 64'd0);
        chk({tag, "_fwdata"}, 64'(fw_data), 64'd0);
        chk({tag, "_cnt"}, 64'(starve_cnt), 64'd0);
        chk({tag, "_rdy"}, {62'd0, req0_ready, req1_ready}, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_rf[i] = '0;
            d_rf[i] = '0;
        end
        repeat (2) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Solo port-0 write.
        req0_valid = 1; req0_addr = 4'd5; req0_data = 32'hA5;
        cycle();
        req0_valid = 0;
        cycle();

        // Contention: port 0 first, port 1 the following cycle.
        req0_valid = 1; req0_addr = 4'd1; req0_data = 32'h11;
        req1_valid = 1; req1_addr = 4'd2; req1_data = 32'h22;
        cycle(); chk("cont_g0", 64'(g0), 64'd1);
        req0_valid = 0;
        cycle(); chk("cont_g1", 64'(g1), 64'd1);
        req1_valid = 0;
        cycle();

        // Starvation: port 1 loses LIMIT times, then wins once.
        req1_valid = 1; req1_addr = 4'd9; req1_data = 32'h99;
        for (int i = 0; i < LIMIT + 2; i++) begin
            req0_valid = 1; req0_addr = 4'(i); req0_data = 32'h100 + 32'(i);
            cycle();
            if (i < LIMIT)       chk("starve_loss", 64'(g1), 64'd0);
            else if (i == LIMIT) chk("starve_win", 64'(g1), 64'd1);
            else                 chk("starve_resume", 64'(g0), 64'd1);
            if (g1) req1_valid = 0;
        end
        req0_valid = 0;
        cycle();

        // Same-address collision: loser's value lands last.
        req0_valid = 1; req0_addr = 4'd7; req0_data = 32'h1;
        req1_valid = 1; req1_addr = 4'd7; req1_data = 32'h2;
        cycle(); req0_valid = 0;
        cycle(); req1_valid = 0;
        cycle();
        chk("collision_r7", 64'(d_rf[7]), 64'h2);

        // Withdraw during port 1's forced turn: port 0 wins that same cycle.
        req1_valid = 1; req1_addr = 4'd3; req1_data = 32'h33;
        for (int i = 0; i < LIMIT; i++) begin
            req0_valid = 1; req0_addr = 4'd4; req0_data = 32'h40 + 32'(i);
            cycle();
        end
        req1_valid = 0; req0_data = 32'h4F;
        cycle();
        chk("withdraw_g0", 64'(g0), 64'd1);
        req0_valid = 0;
        cycle();

        // Randomized traffic honouring hold-until-ready (port 1 may withdraw).
        for (int i = 0; i < 400; i++) begin
            if (!req0_valid && $urandom_range(0, 3) != 0) begin
                req0_valid = 1; req0_addr = 4'($urandom); req0_data = $urandom;
            end
            if (!req1_valid && $urandom_range(0, 1) != 0) begin
                req1_valid = 1; req1_addr = 4'($urandom); req1_data = $urandom;
            end else if (req1_valid && $urandom_range(0, 15) == 0) begin
                req1_valid = 0;
            end
            cycle();
            if (g0) req0_valid = 0;
            if (g1) req1_valid = 0;
        end
        req0_valid = 0; req1_valid = 0;
        cycle();

        // Reset in the cycle a write is presented: everything clears at once.
        req0_valid = 1; req0_addr = 4'd6; req0_data = 32'h66;
        cycle();
        req0_valid = 1; req0_addr = 4'd8; req0_data = 32'h88;
        chk("pre_reset_en", 64'(rf_wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midreset");
        m_losses = 0; m_forced = 1'b0; exp_cnt = 0;
        exp_q.delete();
        req0_valid = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 16; i++) chk("final_rf", 64'(d_rf[i]), 64'(m_rf[i]));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
